load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have the following ports, clock and reset first: Clk, in, 1, sole clock; all state changes on its rising edge.
REQ-002 Reset, in, 1: asynchronous, active-high reset.
REQ-003 req_valid, in, 1: request from the EX/MEM stage.
REQ-004 req_op, in, 3: operation code. 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-005 req_addr, in, 32: byte address.
REQ-006 req_wdata, in, 32: store data, right-aligned.
REQ-007 req_ready, out, 1: unit can accept a request.
REQ-008 rsp_valid, out, 1: one-cycle completion pulse.
REQ-009 rsp_rdata, out, 32: extended load result.
REQ-010 rsp_misalign, out, 1: alignment fault; valid with rsp_valid.
REQ-011 mem_address, out, 32: word index to data memory, equal to {2'b00, addr[31:2]}.
REQ-012 mem_writeData, out, 32: merged word to data memory.
REQ-013 mem_memWrite, out, 1: write strobe; memory commits on the falling Clk edge of the cycle it is high.
REQ-014 mem_memRead, out, 1: read enable; mem_readData is combinationally valid in the same cycle.
REQ-015 mem_readData, in, 32: word returned by data memory.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WRITE and DONE; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 in IDLE, registering op, addr and wdata; inputs SHALL be ignored in every other state.
REQ-018 Misalignment SHALL be defined as LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0; LB, LBU and SB never fault.
REQ-019 A misaligned request SHALL go IDLE->DONE with rsp_misalign=1 and rsp_rdata=0, and SHALL cause no memory access.
REQ-020 An aligned load SHALL go IDLE->READ->DONE, capturing mem_readData at the end of READ; rsp_valid SHALL rise 2 cycles after accept.
REQ-021 SW SHALL go IDLE->WRITE->DONE, with mem_writeData=wdata; rsp_valid SHALL rise 2 cycles after accept.
REQ-022 SH and SB SHALL go IDLE->READ->WRITE->DONE (read-modify-write), and rsp_valid SHALL rise 3 cycles after accept.
REQ-023 The merged word for SH and SB SHALL replace only the addressed lane of the word captured in READ with wdata[15:0] or wdata[7:0] respectively.
REQ-024 Lanes SHALL be little-endian: byte n = bits [8n+7:8n], and halfword at addr[1]=1 = bits [31:16].
REQ-025 Load extension: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected lane; LW SHALL pass the full word.
REQ-026 rsp_rdata SHALL be 0 for stores and faults, and SHALL hold its value only while rsp_valid=1; it SHALL be 0 otherwise.
REQ-027 mem_memRead SHALL be 1 only in READ, and mem_memWrite SHALL be 1 only in WRITE; both SHALL be decoded from registered state only and SHALL never be 1 together.
REQ-028 mem_address SHALL be driven from the registered address in READ and WRITE, and SHALL be 0 in IDLE and DONE; mem_writeData SHALL be 0 outside WRITE.
REQ-029 DONE SHALL last exactly one cycle and then return to IDLE; back-to-back requests SHALL therefore be spaced by at least one idle cycle.
REQ-030 Unused op encodings do not exist; all 8 codes SHALL be legal.

Reset
REQ-031 Reset=1 SHALL immediately force IDLE and clear every register, giving req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_misalign=0 and all mem_* outputs 0, regardless of Clk.
REQ-032 Reset asserted during WRITE before the falling Clk edge SHALL deassert mem_memWrite, so no write commits; no response pulse SHALL follow reset.
REQ-033 After Reset deasserts, the first rising edge with req_valid=1 SHALL be accepted normally.

Verification
REQ-034 With mem word 3 = 0x8077_66F0, an LB at addr 0x0D -> rsp_valid 2 cycles after accept, rsp_rdata=0x0000_0066; LB at 0x0F -> 0xFFFF_FF80; LBU at 0x0F -> 0x0000_0080.
REQ-035 SB wdata=0xAB to addr 0x0E over word 0x8077_66F0 -> READ then WRITE with mem_address=3, mem_writeData=0x80AB_66F0, rsp_valid 3 cycles after accept; a following LW at 0x0C returns 0x80AB_66F0.
REQ-036 LH at 0x0E over 0x8077_66F0 -> 0xFFFF_8077; LHU -> 0x0000_8077; SH 0x1234 at 0x0C -> word becomes 0x8077_1234.
REQ-037 LW at 0x06 and SH at 0x03 -> rsp_valid 1 cycle after accept, rsp_misalign=1, rsp_rdata=0, and mem_memRead/mem_memWrite never asserted.
REQ-038 SW 0xDEAD_BEEF to 0x10 with Reset pulsed high during the WRITE cycle before the falling edge -> word 4 unchanged, outputs all at reset values, no rsp_valid; a new SW after reset succeeds.
REQ-039 req_valid held high continuously with alternating LW/SW -> each accepted only in IDLE, no request lost or duplicated, and memRead and memWrite never high together.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store sequencer; aligns, extends and read-modify-writes sub-word stores.
module load_store_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);
  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, nextState;
  logic [2:0] op;
  logic [31:0] addr, wdata, word, loadData, mergedWord;
  logic [15:0] selHalf;
  logic [7:0] selByte;
  logic isLoad, isFault;
  function automatic logic misaligned(input logic [2:0] o, input logic [1:0] a);
    return ((o == OP_LW || o == OP_SW) && a != 2'b00) ||
           ((o == OP_LH || o == OP_LHU || o == OP_SH) && a[0]);
  endfunction
  assign isLoad = op < OP_SW;
  assign isFault = misaligned(op, addr[1:0]);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      word <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && req_valid) begin
        op <= req_op;
        addr <= req_addr;
        wdata <= req_wdata;
      end
      if (state == READ) word <= mem_readData;
    end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (req_valid) nextState = misaligned(req_op, req_addr[1:0]) ? DONE :
                                        req_op == OP_SW ? WRITE : READ;
      READ:  nextState = isLoad ? DONE : WRITE;
      WRITE: nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  assign selHalf = addr[1] ? word[31:16] : word[15:0];
  assign selByte = word[{addr[1:0], 3'b000} +: 8];
  assign loadData = op == OP_LH  ? {{16{selHalf[15]}}, selHalf} :
                    op == OP_LHU ? {16'b0, selHalf} :
                    op == OP_LB  ? {{24{selByte[7]}}, selByte} :
                    op == OP_LBU ? {24'b0, selByte} : word;
  // Sub-word stores patch only their lane of the word fetched in READ.
  always_comb begin
    mergedWord = word;
    if (op == OP_SW) mergedWord = wdata;
    else if (op == OP_SH) mergedWord[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    else if (op == OP_SB) mergedWord[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign rsp_misalign = state == DONE && isFault;
  assign rsp_rdata = (state == DONE && isLoad && !isFault) ? loadData : 32'b0;
  assign mem_memRead = state == READ;
  assign mem_memWrite = state == WRITE;
  assign mem_address = (state == READ || state == WRITE) ? {2'b00, addr[31:2]} : 32'b0;
  assign mem_writeData = state == WRITE ? mergedWord : 32'b0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests against a word-array reference model.
module tb_load_store_unit;
  logic Clk = 0, Reset = 0, req_valid = 0;
  logic [2:0] req_op = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_misalign, mem_memWrite, mem_memRead;
  logic [31:0] rsp_rdata, mem_address, mem_writeData, mem_readData;
  logic [31:0] dmem [64];
  logic [31:0] refMem [64];
  logic [31:0] lastRd;
  logic lastMis;
  int nChecks = 0, nErrors = 0;
  typedef struct {logic [31:0] rd; logic mis;} rsp_t;
  rsp_t expQ[$];

  load_store_unit dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misalign(rsp_misalign), .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead), .mem_readData(mem_readData)
  );

  always #5 Clk = ~Clk;
  assign mem_readData = dmem[mem_address[5:0]];
  always @(negedge Clk) if (mem_memWrite) dmem[mem_address[5:0]] <= mem_writeData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics: plain arithmetic on a word array, updated as each request commits.
  task automatic modelReq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [31:0] wr, output logic mis,
                          output int lat);
    logic [31:0] w, b, h;
    int bs, hs;
    w = refMem[a[7:2]];
    bs = 8 * (a % 4);
    hs = 16 * ((a / 2) % 2);
    b = (w >> bs) & 32'hFF;
    h = (w >> hs) & 32'hFFFF;
    mis = (op == 0 || op == 5) ? (a % 4 != 0) : (op == 1 || op == 2 || op == 6) ? (a % 2 != 0) : 1'b0;
    rd = 0;
    wr = 0;
    lat = mis ? 1 : (op == 6 || op == 7) ? 3 : 2;
    if (!mis)
      case (op)
        0: rd = w;
        1: rd = h >= 32768 ? (h | 32'hFFFF0000) : h;
        2: rd = h;
        3: rd = b >= 128 ? (b | 32'hFFFFFF00) : b;
        4: rd = b;
        5: wr = wd;
        6: wr = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
        default: wr = (w & ~(32'hFF << bs)) | ((wd & 32'hFF) << bs);
      endcase
    if (!mis && op >= 5) refMem[a[7:2]] = wr;
  endtask

  task automatic doReq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] expRd, expWr;
    logic expMis;
    int expLat, lat;
    bit sawRd, sawWr, sawBoth;
    modelReq(op, a, wd, expRd, expWr, expMis, expLat);
    sawRd = 0; sawWr = 0; sawBoth = 0; lat = 0;
    @(negedge Clk);
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge Clk);
    check("ready", req_ready, 1);
    req_valid = 1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge Clk);
    #1 req_valid = 0;
    req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      if (mem_memRead) begin sawRd = 1; check("rdAddr", mem_address, a >> 2); end
      if (mem_memWrite) begin
        sawWr = 1;
        check("wrAddr", mem_address, a >> 2);
        check("wrData", mem_writeData, expWr);
      end
      if (mem_memRead && mem_memWrite) sawBoth = 1;
      if (rsp_valid) begin
        lat = i;
        lastRd = rsp_rdata;
        lastMis = rsp_misalign;
        check("rdata", rsp_rdata, expRd);
        check("misalign", rsp_misalign, expMis);
        break;
      end
    end
    check("latency", lat, expLat);
    check("sawRead", sawRd, !expMis && op != 5);
    check("sawWrite", sawWr, !expMis && op >= 5);
    check("rdWrBoth", sawBoth, 0);
    @(negedge Clk);
    check("idleValid", rsp_valid, 0);
    check("idleRdata", rsp_rdata, 0);
    check("idleAddr", mem_address, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_valid"}, rsp_valid, 0);
    check({tag, "_rdata"}, rsp_rdata, 0);
    check({tag, "_mis"}, rsp_misalign, 0);
    check({tag, "_rd"}, mem_memRead, 0);
    check({tag, "_wr"}, mem_memWrite, 0);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_wdata"}, mem_writeData, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, wr, a;
    logic mis;
    int lat, accepts, rsps;
    for (int i = 0; i < 64; i++) begin dmem[i] = $urandom; refMem[i] = dmem[i]; end
    #2 Reset = 1;
    #1 checkResetOutputs("reset");
    repeat (2) @(negedge Clk);
    #1 Reset = 0;

    dmem[3] = 32'h807766F0; refMem[3] = 32'h807766F0;
    doReq(3, 32'h0D, 0); check("LB_0D", lastRd, 32'h00000066);
    doReq(3, 32'h0F, 0); check("LB_0F", lastRd, 32'hFFFFFF80);
    doReq(4, 32'h0F, 0); check("LBU_0F", lastRd, 32'h00000080);
    doReq(7, 32'h0E, 32'hAB); check("SB_0E", dmem[3], 32'h80AB66F0);
    doReq(0, 32'h0C, 0); check("LW_0C", lastRd, 32'h80AB66F0);
    dmem[3] = 32'h807766F0; refMem[3] = 32'h807766F0;
    doReq(1, 32'h0E, 0); check("LH_0E", lastRd, 32'hFFFF8077);
    doReq(2, 32'h0E, 0); check("LHU_0E", lastRd, 32'h00008077);
    doReq(6, 32'h0C, 32'h1234); check("SH_0C", dmem[3], 32'h80771234);
    doReq(0, 32'h06, 0); check("LW_06_mis", lastMis, 1);
    doReq(6, 32'h03, 32'h5555); check("SH_03_mis", lastMis, 1);
    check("SH_03_nowrite", dmem[0], refMem[0]);

    // Reset landing in WRITE before the falling edge must cancel the store.
    @(negedge Clk);
    req_valid = 1; req_op = 5; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge Clk);
    #1 req_valid = 0;
    check("rstInWrite", mem_memWrite, 1);
    Reset = 1;
    #1 checkResetOutputs("midReset");
    @(negedge Clk);
    #1 Reset = 0;
    for (int i = 0; i < 3; i++) begin @(negedge Clk); check("noRspAfterReset", rsp_valid, 0); end
    check("word4Kept", dmem[4], refMem[4]);
    doReq(5, 32'h10, 32'hDEADBEEF);
    check("word4New", dmem[4], 32'hDEADBEEF);

    for (int n = 0; n < 150; n++)
      doReq(3'($urandom), $urandom_range(0, 255), $urandom);

    // Continuous req_valid with alternating LW/SW.
    accepts = 0; rsps = 0;
    @(negedge Clk);
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge Clk);
      if (mem_memRead && mem_memWrite) check("burstBoth", 1, 0);
      if (rsp_valid) begin
        rsps++;
        if (expQ.size() == 0) check("burstExtra", 1, 0);
        else begin
          check("burstRdata", rsp_rdata, expQ[0].rd);
          check("burstMis", rsp_misalign, expQ[0].mis);
          void'(expQ.pop_front());
        end
      end
      if (req_ready) begin
        if (c < 70) begin
          a = $urandom_range(0, 63) * 4;
          req_op = accepts % 2 == 0 ? 3'd0 : 3'd5;
          req_addr = a;
          req_wdata = $urandom;
          req_valid = 1;
          modelReq(req_op, a, req_wdata, rd, wr, mis, lat);
          expQ.push_back('{rd: rd, mis: mis});
          accepts++;
        end else req_valid = 0;
      end
    end
    req_valid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      if (rsp_valid) begin
        rsps++;
        if (expQ.size() == 0) check("burstExtra", 1, 0);
        else begin
          check("burstRdata", rsp_rdata, expQ[0].rd);
          void'(expQ.pop_front());
        end
      end
    end
    check("burstCount", rsps, accepts);
    check("burstDrained", expQ.size(), 0);

    for (int i = 0; i < 64; i++) check($sformatf("mem%0d", i), dmem[i], refMem[i]);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
